// File: rtl/vvp_pkg.sv
// rtl/vvp_pkg.sv - shared state encoding and default sizes for the vvp result collector
package vvp_pkg;

  localparam int N_DEF    = 64;
  localparam int ACCW_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } vvp_state_e;

endpackage

// File: rtl/vvp_acc_term.sv
// rtl/vvp_acc_term.sv - one bit-plane term: sign-extend, shift, negate, add, and flag lost signed information
module vvp_acc_term #(
  parameter int SW   = 8,
  parameter int ACCW = 32,
  parameter int SHW  = 5
) (
  input  logic [ACCW-1:0] acc,
  input  logic            restart,
  input  logic [SW-1:0]   s,
  input  logic [SHW-1:0]  shift,
  input  logic            neg,
  output logic [ACCW-1:0] sum,
  output logic            ovf
);

  logic signed [ACCW-1:0] s_ext;
  logic signed [ACCW-1:0] sh;
  logic signed [ACCW+1:0] base_w;
  logic signed [ACCW+1:0] term_w;
  logic signed [ACCW+1:0] sum_w;
  logic                   shift_ovf;
  logic                   add_ovf;

  // Add is done two bits wider so the negate of the most negative term and the carry are exact.
  always_comb begin
    s_ext     = {{(ACCW-SW){s[SW-1]}}, s};
    sh        = s_ext <<< shift;
    shift_ovf = (sh >>> shift) != s_ext;
    base_w    = restart ? '0 : {{2{acc[ACCW-1]}}, acc};
    term_w    = {{2{sh[ACCW-1]}}, sh};
    if (neg) begin
      term_w = -term_w;
    end
    sum_w   = base_w + term_w;
    add_ovf = (sum_w[ACCW+1:ACCW-1] != 3'b000) && (sum_w[ACCW+1:ACCW-1] != 3'b111);
    sum     = sum_w[ACCW-1:0];
    ovf     = shift_ovf | add_ovf;
  end

endmodule

// File: rtl/vvp_collector.sv
// rtl/vvp_collector.sv - accumulates shifted vvp bit-plane sums into one signed word result per in_first..in_last run
module vvp_collector
  import vvp_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SW   = $clog2(N) + 2,
  parameter int ACCW = ACCW_DEF,
  parameter int SHW  = $clog2(ACCW)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [SHW-1:0]         in_shift,
  input  logic                   in_neg,
  input  logic signed [SW-1:0]   S,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic                   out_ovf,
  output logic                   err
);

  vvp_state_e      state;
  vvp_state_e      state_nxt;
  logic [ACCW-1:0] acc;
  logic            ovf_word;
  logic [ACCW-1:0] sum;
  logic            beat_ovf;
  logic            word_ovf;
  logic            fire;
  logic            take;
  logic            emit;
  logic            err_nxt;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;
  assign word_ovf = beat_ovf | (!in_first & ovf_word);

  vvp_acc_term #(
    .SW   (SW),
    .ACCW (ACCW),
    .SHW  (SHW)
  ) u_term (
    .acc     (acc),
    .restart (in_first),
    .s       (S),
    .shift   (in_shift),
    .neg     (in_neg),
    .sum     (sum),
    .ovf     (beat_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A first beat always (re)starts a word; only a missing first in IDLE drops the beat.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    emit      = 1'b0;
    err_nxt   = 1'b0;
    if (fire) begin
      case (state)
        IDLE: begin
          if (in_first) begin
            take = 1'b1;
            if (in_last) begin
              emit = 1'b1;
            end else begin
              state_nxt = ACCUM;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
        ACCUM: begin
          take    = 1'b1;
          err_nxt = in_first;
          if (in_last) begin
            emit      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf_word  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= err_nxt;
      if (take) begin
        acc      <= sum;
        ovf_word <= word_ovf;
      end
      // A new result overwrites a popped one in the same cycle, so no bubble appears.
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= sum;
        out_ovf   <= word_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vvp_collector.sv
// tb/tb_vvp_collector.sv - scoreboard bench for vvp_collector with directed and randomized bit-plane words
module tb_vvp_collector;

  localparam int SW   = 8;
  localparam int ACCW = 32;
  localparam int SHW  = 5;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   in_first = 1'b0;
  logic                   in_last = 1'b0;
  logic [SHW-1:0]         in_shift = '0;
  logic                   in_neg = 1'b0;
  logic signed [SW-1:0]   S = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic signed [ACCW-1:0] out_data;
  logic                   out_ovf;
  logic                   err;

  typedef struct {
    int data;
    bit ovf;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   rdy_mode = 1;
  int   err_exp = 0;
  int   err_seen = 0;
  bit   m_in_word = 1'b0;
  int   m_acc = 0;
  bit   m_ovf = 1'b0;

  always #5 clk = ~clk;

  vvp_collector #(
    .N    (64),
    .SW   (SW),
    .ACCW (ACCW),
    .SHW  (SHW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_shift  (in_shift),
    .in_neg    (in_neg),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .err       (err)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Exact integer arithmetic; anything not representable in 32 signed bits is an overflow.
  function automatic void model_beat(input int base, input int s, input int sh, input bit neg,
                                     output int sum, output bit ovf);
    longint ex_sh;
    longint t;
    longint ex;
    ex_sh = longint'(s) * (longint'(1) << sh);
    ovf   = (ex_sh > MAXV) || (ex_sh < MINV);
    t     = longint'(int'(ex_sh));
    if (neg) t = -t;
    ex = longint'(base) + t;
    if ((ex > MAXV) || (ex < MINV)) ovf = 1'b1;
    sum = int'(ex);
  endfunction

  task automatic send_beat(input int s, input int sh, input bit neg, input bit first, input bit last);
    int waitc;
    int sum;
    bit bovf;
    waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_first = first;
    in_last  = last;
    in_shift = SHW'(sh);
    in_neg   = neg;
    S        = SW'(s);
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!m_in_word && !first) begin
      err_exp++;
    end else begin
      if (m_in_word && first) err_exp++;
      model_beat(first ? 0 : m_acc, s, sh, neg, sum, bovf);
      m_ovf = bovf | (!first & m_ovf);
      m_acc = sum;
      if (last) begin
        expq.push_back('{sum, m_ovf});
        m_in_word = 1'b0;
      end else begin
        m_in_word = 1'b1;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_ovf", out_ovf, mon_e.ovf);
      end
    end
    if (err) err_seen++;
  end

  initial begin
    longint t0;
    int     k;
    int     s;
    int     sh;
    bit     first;
    bit     last;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    send_beat(64, 0, 0, 1, 1);
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 64);
    chk("single_ovf", out_ovf, 0);
    chk("single_err", err, 0);

    send_beat(64, 0, 0, 1, 0);
    send_beat(64, 1, 1, 0, 1);
    @(negedge clk);
    chk("signed_d_data", out_data, -64);

    rdy_mode = 2;
    send_beat(7, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 7);
    end
    rdy_mode = 1;
    send_beat(-3, 0, 0, 1, 1);
    @(negedge clk);
    chk("bp_no_bubble_valid", out_valid, 1);
    chk("bp_new_data", out_data, -3);

    send_beat(9, 0, 0, 0, 1);
    @(negedge clk);
    chk("idle_nofirst_err", err, 1);
    chk("idle_nofirst_no_out", out_valid, 0);
    @(negedge clk);
    chk("idle_nofirst_err_pulse", err, 0);

    send_beat(100, 0, 0, 1, 0);
    send_beat(50, 2, 0, 0, 0);
    send_beat(11, 0, 0, 1, 0);
    @(negedge clk);
    chk("restart_err", err, 1);
    send_beat(2, 1, 0, 0, 1);
    @(negedge clk);
    chk("restart_data", out_data, 15);
    chk("restart_err_pulse", err, 0);

    send_beat(64, ACCW - 6, 0, 1, 1);
    @(negedge clk);
    chk("ovf_set", out_ovf, 1);
    send_beat(1, 0, 0, 1, 1);
    @(negedge clk);
    chk("ovf_cleared", out_ovf, 0);
    chk("ovf_next_data", out_data, 1);

    send_beat(3, 0, 0, 1, 1);
    t0 = $time;
    for (int i = 0; i < 8; i++) send_beat(i + 1, i, i % 2, 1, 1);
    chk("b2b_cycles", ($time - t0) / 10, 8);

    k = 0;
    while ((expq.size() != 0 || out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    send_beat(20, 0, 0, 1, 0);
    send_beat(20, 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_ovf", out_ovf, 0);
    chk("midrst_err", err, 0);
    m_in_word = 1'b0;
    m_acc     = 0;
    m_ovf     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(8, 0, 0, 0, 1);
    send_beat(5, 0, 0, 1, 1);
    @(negedge clk);
    chk("post_rst_data", out_data, 5);

    rdy_mode = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_in_word) first = ($urandom_range(0, 15) == 0);
      else           first = ($urandom_range(0, 15) != 0);
      last = ($urandom_range(0, 2) == 0);
      s    = int'($urandom_range(0, 255)) - 128;
      sh   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      send_beat(s, sh, $urandom_range(0, 3) == 0, first, last);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end

    rdy_mode = 1;
    if (m_in_word) send_beat(1, 0, 0, 0, 1);
    k = 0;
    while ((expq.size() != 0 || out_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    chk("err_count", err_seen, err_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
